// File: rtl/debug_step_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : debug_step_if                                                   |
// | Brief    : Command, core-control and transmit signals of the debug stepper |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
interface debug_step_if #(
    parameter int PC_W = 8
);
    logic            cmd_valid;
    logic [7:0]      cmd_data;
    logic            halt_in;
    logic [PC_W-1:0] pc_in;
    logic            tx_ready;
    logic            enableDebug;
    logic            resetDebug;
    logic            tx_valid;
    logic [7:0]      tx_data;
    logic            busy;

    modport master (
        input  cmd_valid, cmd_data, halt_in, pc_in, tx_ready,
        output enableDebug, resetDebug, tx_valid, tx_data, busy
    );

    modport slave (
        output cmd_valid, cmd_data, halt_in, pc_in, tx_ready,
        input  enableDebug, resetDebug, tx_valid, tx_data, busy
    );
endinterface
`default_nettype wire

// File: rtl/debug_step_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : debug_step_controller                                           |
// | Brief    : Run/pause/step/reset control of the core from UART command      |
// |            bytes; dumps PC and cycle count as a byte stream. Define        |
// |            DBG_ECHO_EN to echo every accepted command byte first.          |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module debug_step_controller #(
    parameter int PC_W         = 8,
    parameter int CNT_W        = 16,
    parameter int RESET_CYCLES = 2
) (
    input  logic         clk,
    input  logic         reset,
    debug_step_if.master dbg
);

    localparam int c_NBYTES = CNT_W / 8;
    localparam int c_BW     = $clog2(c_NBYTES + 1);
    localparam int c_RW     = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    localparam logic [7:0] c_CMD_RUN   = 8'h63;
    localparam logic [7:0] c_CMD_PAUSE = 8'h70;
    localparam logic [7:0] c_CMD_STEP  = 8'h73;
    localparam logic [7:0] c_CMD_RST   = 8'h72;
    localparam logic [7:0] c_CMD_DUMP  = 8'h64;

    localparam logic [2:0] c_ST_IDLE = 3'd0;
    localparam logic [2:0] c_ST_RUN  = 3'd1;
    localparam logic [2:0] c_ST_STEP = 3'd2;
    localparam logic [2:0] c_ST_RST  = 3'd3;
    localparam logic [2:0] c_ST_SEND = 3'd4;
`ifdef DBG_ECHO_EN
    localparam logic [2:0] c_ST_ECHO = 3'd5;
    logic [7:0]        r_echo_cmd;
`endif

    logic [2:0]        r_state;
    logic [2:0]        w_next_state;
    logic              r_enable;
    logic              r_reset_dbg;
    logic              r_busy;
    logic              r_tx_valid;
    logic [7:0]        r_tx_data;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_next;
    logic [CNT_W-1:0]  r_shift;
    logic [c_BW-1:0]   r_bytes_left;
    logic [c_RW-1:0]   r_rst_cnt;
    logic [PC_W-1:0]   w_pc;
    logic              w_xfer;
    logic              w_idle_cmd;

    assign w_pc       = dbg.pc_in;
    assign w_xfer     = r_tx_valid & dbg.tx_ready;
    assign w_idle_cmd = dbg.cmd_valid &&
                        (dbg.cmd_data == c_CMD_RUN  || dbg.cmd_data == c_CMD_STEP ||
                         dbg.cmd_data == c_CMD_RST  || dbg.cmd_data == c_CMD_DUMP);

    function automatic logic [2:0] f_target(input logic [7:0] cmd);
        case (cmd)
            c_CMD_RUN:  f_target = c_ST_RUN;
            c_CMD_STEP: f_target = c_ST_STEP;
            c_CMD_RST:  f_target = c_ST_RST;
            c_CMD_DUMP: f_target = c_ST_SEND;
            default:    f_target = c_ST_IDLE;
        endcase
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= c_ST_IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_idle_cmd) begin
`ifdef DBG_ECHO_EN
                    w_next_state = c_ST_ECHO;
`else
                    w_next_state = f_target(dbg.cmd_data);
`endif
                end
            end
            c_ST_RUN: begin
                // halt takes priority over a simultaneous pause
                if (dbg.halt_in) begin
                    w_next_state = c_ST_SEND;
                end else if (dbg.cmd_valid && dbg.cmd_data == c_CMD_PAUSE) begin
`ifdef DBG_ECHO_EN
                    w_next_state = c_ST_ECHO;
`else
                    w_next_state = c_ST_IDLE;
`endif
                end
            end
            c_ST_STEP: w_next_state = c_ST_SEND;
            c_ST_RST: begin
                if (r_rst_cnt == c_RW'(RESET_CYCLES - 1)) w_next_state = c_ST_IDLE;
            end
            c_ST_SEND: begin
                if (w_xfer && r_bytes_left == '0) w_next_state = c_ST_IDLE;
            end
`ifdef DBG_ECHO_EN
            c_ST_ECHO: begin
                if (w_xfer) w_next_state = f_target(r_echo_cmd);
            end
`endif
            default: w_next_state = c_ST_IDLE;
        endcase
    end

    always_comb begin
        w_cnt_next = r_cnt;
        if (w_next_state == c_ST_RST)               w_cnt_next = '0;
        else if (r_enable && r_cnt != c_CNT_MAX)    w_cnt_next = r_cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_enable     <= 1'b0;
            r_reset_dbg  <= 1'b0;
            r_busy       <= 1'b0;
            r_tx_valid   <= 1'b0;
            r_tx_data    <= 8'h00;
            r_cnt        <= '0;
            r_shift      <= '0;
            r_bytes_left <= '0;
            r_rst_cnt    <= '0;
`ifdef DBG_ECHO_EN
            r_echo_cmd   <= 8'h00;
`endif
        end else begin
            r_enable    <= (w_next_state == c_ST_RUN) || (w_next_state == c_ST_STEP);
            r_reset_dbg <= (w_next_state == c_ST_RST);
            r_busy      <= !((w_next_state == c_ST_IDLE) || (w_next_state == c_ST_RUN));
            r_cnt       <= w_cnt_next;
            r_rst_cnt   <= (r_state == c_ST_RST) ? r_rst_cnt + 1'b1 : '0;

            // snapshot uses the post-edge count so the last enabled cycle is included
            if (w_next_state == c_ST_SEND && r_state != c_ST_SEND) begin
                r_tx_valid   <= 1'b1;
                r_tx_data    <= w_pc[7:0];
                r_shift      <= w_cnt_next;
                r_bytes_left <= c_BW'(c_NBYTES);
`ifdef DBG_ECHO_EN
            end else if (w_next_state == c_ST_ECHO && r_state != c_ST_ECHO) begin
                r_tx_valid   <= 1'b1;
                r_tx_data    <= dbg.cmd_data;
                r_echo_cmd   <= dbg.cmd_data;
`endif
            end else if (w_xfer) begin
                if (r_state == c_ST_SEND && r_bytes_left != '0) begin
                    r_tx_data    <= r_shift[CNT_W-1 -: 8];
                    r_shift      <= r_shift << 8;
                    r_bytes_left <= r_bytes_left - 1'b1;
                end else begin
                    r_tx_valid   <= 1'b0;
                    r_tx_data    <= 8'h00;
                end
            end
        end
    end

    assign dbg.enableDebug = r_enable;
    assign dbg.resetDebug  = r_reset_dbg;
    assign dbg.busy        = r_busy;
    assign dbg.tx_valid    = r_tx_valid;
    assign dbg.tx_data     = r_tx_data;

endmodule
`default_nettype wire

// File: doc/debug_step_controller.md
Name: debug_step_controller

Overview:
- Debug-side initiator for the processor core's debug inputs.
- Decodes single-byte commands from the UART receiver.
- Drives `enableDebug` / `resetDebug` into the Program_Counter and pipeline to run, pause, single-step or reset the core.
- Returns a snapshot of the current PC and an execution cycle count as a byte stream to the UART transmitter, using a valid/ready handshake.

Parameters:
- PC_W, 8: width of the PC input. Only the low 8 bits are transmitted.
- CNT_W, 16: cycle counter width. Must be a multiple of 8; sent as CNT_W/8 bytes, MSB first.
- RESET_CYCLES, 2: number of cycles `resetDebug` is held high for an 'r' command (minimum 1).

Ports:
- clk, input, 1: system clock; all state changes on the rising edge.
- reset, input, 1: asynchronous, active-low reset.
- cmd_valid, input, 1: one-cycle strobe; cmd_data is valid.
- cmd_data, input, 8: command byte from the UART receiver.
- halt_in, input, 1: core reached its halt instruction.
- pc_in, input, PC_W: PC value (Program_Counter addr_out).
- tx_ready, input, 1: UART transmitter can accept a byte.
- enableDebug, output, 1: high = core advances this cycle.
- resetDebug, output, 1: high = synchronous reset request to the core.
- tx_valid, output, 1: tx_data holds a byte to send.
- tx_data, output, 8: byte to transmit.
- busy, output, 1: high in any state other than IDLE and RUN.

Behaviour:
- Reset (reset=0, asynchronous) sets:
  - state = IDLE
  - enableDebug = 0, resetDebug = 0
  - tx_valid = 0, tx_data = 0x00
  - busy = 0, cycle_cnt = 0
- All outputs are registered. A command strobed in cycle N changes outputs in cycle N+1.
- Commands:
  - 0x63 'c' = run
  - 0x70 'p' = pause
  - 0x73 's' = step
  - 0x72 'r' = reset core
  - 0x64 'd' = dump
  - Any other byte: ignored, no state change.
- States and transitions:
  - IDLE:
    - 'c' -> RUN.
    - 's' -> STEP.
    - 'r' -> RST.
    - 'd' -> SEND.
    - 'p' -> ignored.
  - RUN:
    - enableDebug = 1.
    - 'p' -> IDLE; enableDebug = 0 from the next cycle.
    - halt_in = 1 -> SEND; enableDebug = 0.
    - halt_in and 'p' in the same cycle: halt wins (-> SEND).
    - All other commands are ignored.
  - STEP:
    - enableDebug = 1 for exactly one cycle, then -> SEND.
    - halt_in is ignored.
  - RST:
    - resetDebug = 1 and enableDebug = 0 for RESET_CYCLES cycles.
    - cycle_cnt cleared to 0.
    - Then -> IDLE.
  - SEND:
    - On entry, snapshot pc_in[7:0] and cycle_cnt.
    - Transmit PC byte, then the count bytes MSB first.
    - tx_valid is held and tx_data is stable until tx_ready.
    - A byte transfers in a cycle where tx_valid & tx_ready.
    - After the last transfer, tx_valid = 0 in the next cycle -> IDLE.
- Commands in STEP, RST or SEND are dropped (busy = 1), never queued.
- cycle_cnt:
  - Increments on every cycle with enableDebug = 1.
  - Saturates at 2^CNT_W - 1; no wrap.
  - Cleared only by reset or RST.
- PC stability: pc_in changing during SEND does not alter bytes already snapshotted.
- Mid-operation reset: reset asserted during SEND or RST aborts immediately to the reset values. No partial byte remains valid.

Optional Feature:
- Macro: DBG_ECHO_EN.
- When defined:
  - Every accepted command (not ignored or dropped ones) is first echoed as one tx byte, using the same handshake, in an ECHO state.
  - The command's action starts the cycle after the echo transfers.
  - 'd' and 's' output = echo byte followed by the dump bytes.
- When undefined: no ECHO state; commands act in the next cycle as specified above.

Test Plan:
- Reset then 'd' with pc_in = 0x00 and tx_ready = 1 -> tx bytes 0x00, 0x00, 0x00; busy high for 3 transfer cycles; then IDLE.
- 'c', wait 10 cycles, 'p' with pc_in = 0x0A, then 'd' -> enableDebug high for exactly 11 cycles; bytes 0x0A, 0x00, 0x0B.
- 's' with pc_in = 0x06 and tx_ready low for 5 cycles -> enableDebug high for exactly 1 cycle; tx_valid held with tx_data = 0x06 stable until tx_ready; count bytes 0x00, 0x01.
- RUN, then halt_in and 'p' in the same cycle -> SEND entered (dump emitted), enableDebug low the next cycle.
- 'r' with RESET_CYCLES = 2 -> resetDebug high for exactly 2 cycles; a subsequent 'd' shows count 0x0000. A 'c' issued during RST is ignored (state stays IDLE afterwards).
- reset pulled low mid-SEND after the first byte -> tx_valid = 0 and state IDLE immediately (asynchronously); no further bytes.
- Unknown byte 0x41 in IDLE -> no output change.
